// File: rtl/sram_req_queue.sv
// sram_req_queue: in-order request FIFO that drives the SRAM controller with
// one-cycle read/write strobes and returns read data on a buffered response port.
module sram_req_queue #(
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned ADDR_W      = 18,
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned ACK_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   input  logic              rsp_ready,
   output logic              sram_write,
   output logic              sram_read,
   output logic [ADDR_W-1:0] sram_address,
   output logic [DATA_W-1:0] sram_data_write,
   input  logic              sram_ready,
   input  logic [DATA_W-1:0] sram_data_read,
   output logic              busy,
   output logic              timeout_err
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned ENT_W = 1 + ADDR_W + DATA_W;
   localparam int unsigned TMR_W = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_ACK,
      S_WAIT_DONE
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;

   logic [ENT_W-1:0]   r_mem [DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [PTR_W:0]     r_count;
   logic [TMR_W-1:0]   r_timer;

   logic               r_cmd_we;
   logic [ADDR_W-1:0]  r_address;
   logic [DATA_W-1:0]  r_wdata;
   logic               r_sram_write;
   logic               r_sram_read;
   logic               r_rsp_valid;
   logic [DATA_W-1:0]  r_rsp_data;
   logic               r_timeout_err;

   logic               w_full;
   logic               w_empty;
   logic               w_push;
   logic               w_pop;
   logic               w_complete;
   logic               w_timeout;
   logic               w_tmr_inc;
   logic [ENT_W-1:0]   w_head;
   logic               w_head_we;

   assign w_full    = (r_count == (PTR_W+1)'(DEPTH));
   assign w_empty   = (r_count == '0);
   assign w_push    = req_valid && !w_full;
   assign w_head    = r_mem[r_rd_ptr];
   assign w_head_we = w_head[ENT_W-1];

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= {req_we, req_addr, req_wdata};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         if (w_push && !w_pop)      r_count <= r_count + (PTR_W+1)'(1);
         else if (w_pop && !w_push) r_count <= r_count - (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // A read may only launch once the previous response has been taken,
   // since there is a single response buffer.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_complete  = 1'b0;
      w_timeout   = 1'b0;
      w_tmr_inc   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty && sram_ready && (w_head_we || !r_rsp_valid)) begin
               w_pop       = 1'b1;
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: w_state_nxt = S_WAIT_ACK;
         S_WAIT_ACK: begin
            if (!sram_ready) begin
               w_state_nxt = S_WAIT_DONE;
            end else if (r_timer == TMR_W'(ACK_TIMEOUT - 1)) begin
               w_timeout   = 1'b1;
               w_complete  = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_tmr_inc   = 1'b1;
            end
         end
         S_WAIT_DONE: begin
            if (sram_ready) begin
               w_complete  = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_timer       <= '0;
         r_cmd_we      <= 1'b0;
         r_address     <= '0;
         r_wdata       <= '0;
         r_sram_write  <= 1'b0;
         r_sram_read   <= 1'b0;
         r_rsp_valid   <= 1'b0;
         r_rsp_data    <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_sram_write <= w_pop && w_head_we;
         r_sram_read  <= w_pop && !w_head_we;
         if (w_pop) begin
            r_cmd_we  <= w_head_we;
            r_address <= w_head[ADDR_W+DATA_W-1:DATA_W];
            r_wdata   <= w_head[DATA_W-1:0];
         end
         if (r_state == S_ISSUE) r_timer <= '0;
         else if (w_tmr_inc)     r_timer <= r_timer + TMR_W'(1);
         if (w_complete && !r_cmd_we) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= sram_data_read;
         end else if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
         end
         if (w_timeout) r_timeout_err <= 1'b1;
      end
   end

   assign req_ready       = !w_full;
   assign rsp_valid       = r_rsp_valid;
   assign rsp_data        = r_rsp_data;
   assign sram_write      = r_sram_write;
   assign sram_read       = r_sram_read;
   assign sram_address    = r_address;
   assign sram_data_write = r_wdata;
   assign busy            = (r_state != S_IDLE) || !w_empty || r_rsp_valid;
   assign timeout_err     = r_timeout_err;

endmodule

// File: tb/tb_sram_req_queue.sv
// Scoreboard bench for sram_req_queue: an in-order request/memory reference
// model predicts commands and read data; a negedge monitor checks the DUT.
module tb_sram_req_queue;
   localparam int unsigned ADDR_W = 18;
   localparam int unsigned DATA_W = 16;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_we = 1'b0;
   logic [ADDR_W-1:0] req_addr = '0;
   logic [DATA_W-1:0] req_wdata = '0;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_ready = 1'b0;
   logic              sram_write;
   logic              sram_read;
   logic [ADDR_W-1:0] sram_address;
   logic [DATA_W-1:0] sram_data_write;
   logic              sram_ready;
   logic [DATA_W-1:0] sram_data_read;
   logic              busy;
   logic              timeout_err;

   sram_req_queue #(.DEPTH(4), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACK_TIMEOUT(15)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
      .sram_write(sram_write), .sram_read(sram_read), .sram_address(sram_address),
      .sram_data_write(sram_data_write), .sram_ready(sram_ready),
      .sram_data_read(sram_data_read), .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } cmd_t;

   cmd_t              cmd_q[$];
   logic [DATA_W-1:0] rsp_q[$];
   logic [DATA_W-1:0] ref_mem[16];
   logic [DATA_W-1:0] ctl_mem[16];

   int unsigned n_checks = 0;
   int unsigned n_err    = 0;
   int unsigned n_strobe = 0;

   bit          ctl_hold  = 1'b0;
   bit          ctl_stuck = 1'b0;
   bit          ctl_rand  = 1'b0;
   int unsigned ctl_d1    = 1;
   int unsigned ctl_d2    = 3;
   bit          rsp_rand  = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: requests take effect in acceptance order.
   task automatic model_push(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      cmd_t c;
      c.we = we; c.addr = a; c.data = d;
      cmd_q.push_back(c);
      if (we) ref_mem[a[3:0]] = d;
      else    rsp_q.push_back(ref_mem[a[3:0]]);
   endtask

   task automatic try_send(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           output bit ok);
      req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1;
      ok = req_ready;
      if (ok) model_push(we, a, d);
      tick();
      req_valid = 1'b0;
   endtask

   task automatic send(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      bit ok = 1'b0;
      for (int unsigned n = 0; n < 300 && !ok; n++) try_send(we, a, d, ok);
      chk("send_accepted", 64'(ok), 64'd1);
   endtask

   task automatic wait_idle(input string name, input int unsigned budget);
      for (int unsigned n = 0; n < budget && busy; n++) tick();
      chk(name, 64'(busy), 64'd0);
   endtask

   task automatic wait_rsp(input string name, input int unsigned budget);
      for (int unsigned n = 0; n < budget && !rsp_valid; n++) tick();
      chk(name, 64'(rsp_valid), 64'd1);
   endtask

   // Controller model: acknowledges each strobe by dropping then raising ready.
   initial begin : controller
      logic       c_we;
      logic [3:0] c_a;
      int unsigned d1, d2;
      sram_ready     = 1'b1;
      sram_data_read = '0;
      forever begin
         tick();
         if (ctl_hold) begin
            sram_ready = 1'b0;
         end else if (sram_write || sram_read) begin
            c_we = sram_write;
            c_a  = sram_address[3:0];
            if (c_we) ctl_mem[c_a] = sram_data_write;
            if (!ctl_stuck) begin
               d1 = ctl_rand ? $urandom_range(1, 3) : ctl_d1;
               d2 = ctl_rand ? $urandom_range(1, 4) : ctl_d2;
               repeat (d1) tick();
               sram_ready = 1'b0;
               repeat (d2) tick();
               if (!c_we) sram_data_read = ctl_mem[c_a];
               sram_ready = 1'b1;
            end
         end else begin
            sram_ready = 1'b1;
         end
      end
   end

   initial begin : rsp_driver
      forever begin
         tick();
         if (rsp_rand) rsp_ready = 1'($urandom_range(0, 1));
      end
   end

   // Monitor: compares every issued command and every consumed response.
   logic              prev_strobe = 1'b0;
   logic [ADDR_W-1:0] last_addr   = '0;
   logic [DATA_W-1:0] last_data   = '0;

   always @(negedge clk) begin : monitor
      cmd_t e;
      if (!reset_n) begin
         prev_strobe = 1'b0;
         last_addr   = '0;
         last_data   = '0;
      end else begin
         if (sram_write || sram_read) begin
            n_strobe++;
            chk("strobe_exclusive", 64'(sram_write && sram_read), 64'd0);
            chk("strobe_width", 64'(prev_strobe), 64'd0);
            if (sram_read) chk("read_while_rsp_pending", 64'(rsp_valid), 64'd0);
            if (cmd_q.size() == 0) begin
               chk("unexpected_cmd", 64'(cmd_q.size()), 64'd1);
            end else begin
               e = cmd_q.pop_front();
               chk("cmd_we", 64'(sram_write), 64'(e.we));
               chk("cmd_addr", 64'(sram_address), 64'(e.addr));
               if (e.we) chk("cmd_wdata", 64'(sram_data_write), 64'(e.data));
               last_addr = e.addr;
               last_data = e.we ? e.data : sram_data_write;
            end
         end else begin
            chk("addr_stable", 64'(sram_address), 64'(last_addr));
            chk("wdata_stable", 64'(sram_data_write), 64'(last_data));
         end
         prev_strobe = sram_write || sram_read;
         if (rsp_valid && rsp_ready) begin
            if (rsp_q.size() == 0) chk("unexpected_rsp", 64'(rsp_q.size()), 64'd1);
            else                   chk("rsp_data", 64'(rsp_data), 64'(rsp_q.pop_front()));
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      bit          ok;
      int unsigned acc, s0, t0, t1, t2;
      for (int i = 0; i < 16; i++) begin
         ref_mem[i] = '0;
         ctl_mem[i] = '0;
      end

      #3;
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_data", 64'(rsp_data), 64'd0);
      chk("rst_strobes", 64'({sram_write, sram_read}), 64'd0);
      chk("rst_addr", 64'(sram_address), 64'd0);
      chk("rst_wdata", 64'(sram_data_write), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_timeout", 64'(timeout_err), 64'd0);
      repeat (2) tick();
      reset_n = 1'b1;
      tick();

      // Single write with a fixed controller handshake.
      ctl_d1 = 1; ctl_d2 = 3;
      send(1'b1, 18'h00000, 16'hAAAA);
      wait_idle("t1_busy_clear", 50);
      chk("t1_no_rsp", 64'(rsp_valid), 64'd0);

      // Read returns controller data; response held until consumed.
      send(1'b1, 18'h00000, 16'h0A0A);
      send(1'b0, 18'h00000, 16'h0000);
      wait_rsp("t2_rsp_arrives", 50);
      chk("t2_rsp_data", 64'(rsp_data), 64'h0A0A);
      repeat (3) tick();
      chk("t2_rsp_held", 64'(rsp_valid), 64'd1);
      chk("t2_rsp_data_held", 64'(rsp_data), 64'h0A0A);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("t2_rsp_cleared", 64'(rsp_valid), 64'd0);
      wait_idle("t2_idle", 50);

      // FIFO fill with controller busy; order checked by the scoreboard.
      ctl_hold = 1'b1;
      repeat (2) tick();
      acc = 0;
      for (int unsigned i = 0; i < 5; i++) begin
         try_send(1'(i % 2), 18'($urandom()), 16'($urandom()), ok);
         if (ok) acc++;
      end
      chk("t3_accepted", 64'(acc), 64'd4);
      chk("t3_req_ready_full", 64'(req_ready), 64'd0);
      rsp_rand = 1'b1;
      ctl_hold = 1'b0;
      wait_idle("t3_drain", 300);
      rsp_rand = 1'b0;
      tick();
      rsp_ready = 1'b0;

      // Second read waits for the first response to be consumed.
      send(1'b0, 18'h00005, 16'h0000);
      send(1'b0, 18'h00006, 16'h0000);
      send(1'b1, 18'h00005, 16'h5A5A);
      wait_rsp("t4_rsp_a", 50);
      s0 = n_strobe;
      repeat (12) tick();
      chk("t4_b_blocked", 64'(n_strobe - s0), 64'd0);
      chk("t4_busy", 64'(busy), 64'd1);
      rsp_ready = 1'b1;
      wait_idle("t4_drain", 100);
      rsp_ready = 1'b0;

      // Stuck controller: ACK timeout after 15 WAIT_ACK cycles.
      ctl_hold = 1'b1;
      repeat (2) tick();
      send(1'b1, 18'h00003, 16'h1234);
      send(1'b1, 18'h00004, 16'h4321);
      ctl_stuck = 1'b1;
      ctl_hold  = 1'b0;
      t0 = 0;
      for (int unsigned n = 0; n < 20 && !sram_write; n++) tick();
      chk("t5_first_strobe", 64'(sram_write), 64'd1);
      for (int unsigned n = 0; n < 40 && !timeout_err; n++) begin tick(); t0++; end
      chk("t5_timeout_latency", 64'(t0), 64'd16);
      t1 = t0;
      for (int unsigned n = 0; n < 10 && !sram_write; n++) begin tick(); t1++; end
      chk("t5_next_issue", 64'(t1), 64'd17);
      wait_idle("t5_idle", 60);
      ctl_stuck = 1'b0;
      chk("t5_sticky", 64'(timeout_err), 64'd1);

      // Reset while in WAIT_DONE with two entries queued.
      ctl_d1 = 1; ctl_d2 = 10;
      rsp_ready = 1'b1;
      ctl_hold = 1'b1;
      repeat (2) tick();
      for (int unsigned i = 0; i < 3; i++) try_send(1'b0, 18'(i + 8), 16'h0, ok);
      ctl_hold = 1'b0;
      s0 = n_strobe;
      for (int unsigned n = 0; n < 20 && n_strobe == s0; n++) tick();
      for (int unsigned n = 0; n < 20 && sram_ready; n++) tick();
      chk("t6_ctl_busy", 64'(sram_ready), 64'd0);
      tick();
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t6_rst_busy", 64'(busy), 64'd0);
      chk("t6_rst_req_ready", 64'(req_ready), 64'd1);
      chk("t6_rst_strobes", 64'({sram_write, sram_read}), 64'd0);
      chk("t6_rst_addr", 64'(sram_address), 64'd0);
      chk("t6_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("t6_rst_timeout", 64'(timeout_err), 64'd0);
      cmd_q.delete();
      rsp_q.delete();
      repeat (2) tick();
      reset_n = 1'b1;
      s0 = n_strobe;
      repeat (30) tick();
      chk("t6_no_stale_issue", 64'(n_strobe - s0), 64'd0);
      chk("t6_idle", 64'(busy), 64'd0);

      // Randomized traffic against the reference model.
      ctl_rand = 1'b1;
      rsp_rand = 1'b1;
      for (int unsigned i = 0; i < 40; i++) begin
         send(1'($urandom_range(0, 1)), 18'($urandom()), 16'($urandom()));
         t2 = $urandom_range(0, 3);
         repeat (t2) tick();
      end
      wait_idle("rand_drain", 1000);
      chk("rand_cmd_q_empty", 64'(cmd_q.size()), 64'd0);
      chk("rand_rsp_q_empty", 64'(rsp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
